// File: rtl/onehot_encoder_pkg.sv
// Shared helpers for the one-hot encoder slice.
package onehot_encoder_pkg;

  // Index width for a given code width, never below 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_decode_core.sv
// Purely combinational index-to-one-hot decoder with range detection.
module onehot_decode_core #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int INPUT_WIDTH  = 4
) (
  input  logic [INPUT_WIDTH-1:0]  value_i,
  input  logic                    en_i,
  output logic [OUTPUT_WIDTH-1:0] code_o,
  output logic                    range_err_o
);

  // One extra bit so OUTPUT_WIDTH == 2**INPUT_WIDTH is representable.
  localparam logic [INPUT_WIDTH:0] LIMIT = (INPUT_WIDTH+1)'(OUTPUT_WIDTH);

  logic w_oor;
  assign w_oor = ({1'b0, value_i} >= LIMIT);

  for (genvar i = 0; i < OUTPUT_WIDTH; i++) begin : g_bit
    assign code_o[i] = en_i && (value_i == INPUT_WIDTH'(i));
  end

  assign range_err_o = en_i & w_oor;

endmodule

// File: rtl/onehot_encoder.sv
// Binary-to-one-hot encoder: combinational code plus a one-cycle registered copy.
module onehot_encoder
  import onehot_encoder_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 16,
  parameter int INPUT_WIDTH  = clog2_min1(OUTPUT_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [INPUT_WIDTH-1:0]  value_i,
  input  logic                    en_out_i,
  output logic [OUTPUT_WIDTH-1:0] code_o,
  output logic                    range_err_o,
  output logic [OUTPUT_WIDTH-1:0] code_q_o,
  output logic                    valid_q_o,
  output logic                    range_err_q_o
);

  if (OUTPUT_WIDTH < 2 || INPUT_WIDTH < $clog2(OUTPUT_WIDTH)) begin : g_param_chk
    $error("onehot_encoder: OUTPUT_WIDTH must be >= 2 and INPUT_WIDTH >= $clog2(OUTPUT_WIDTH)");
  end

  logic [OUTPUT_WIDTH-1:0] w_code;
  logic                    w_err;
  logic [OUTPUT_WIDTH-1:0] r_code;
  logic                    r_valid;
  logic                    r_err;

  onehot_decode_core #(
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_core (
    .value_i    (value_i),
    .en_i       (en_out_i),
    .code_o     (w_code),
    .range_err_o(w_err)
  );

  // No load enable: en_out_i already zeroes the data when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_code  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_code  <= w_code;
      r_valid <= en_out_i & ~w_err;
      r_err   <= w_err;
    end
  end

  assign code_o        = w_code;
  assign range_err_o   = w_err;
  assign code_q_o      = r_code;
  assign valid_q_o     = r_valid;
  assign range_err_q_o = r_err;

  always_ff @(posedge clk_i) begin
    a_onehot0 : assert ($onehot0(w_code));
    a_onehot  : assert ($onehot(w_code) == (en_out_i & ~w_err));
    a_vld_oh  : assert (!r_valid || $onehot(r_code));
    a_excl    : assert (!(r_valid && r_err));
  end

endmodule

// File: tb/tb_onehot_encoder.sv
// Directed and random checks for onehot_encoder at widths 16 and 10.
module tb_onehot_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v16, v10;
  logic        en16, en10;
  logic [15:0] code16, codeq16;
  logic        err16, vq16, errq16;
  logic [9:0]  code10, codeq10;
  logic        err10, vq10, errq10;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onehot_encoder #(.OUTPUT_WIDTH(16)) u16 (
    .clk_i(clk), .rst_i(rst), .value_i(v16), .en_out_i(en16),
    .code_o(code16), .range_err_o(err16),
    .code_q_o(codeq16), .valid_q_o(vq16), .range_err_q_o(errq16)
  );

  onehot_encoder #(.OUTPUT_WIDTH(10), .INPUT_WIDTH(4)) u10 (
    .clk_i(clk), .rst_i(rst), .value_i(v10), .en_out_i(en10),
    .code_o(code10), .range_err_o(err10),
    .code_q_o(codeq10), .valid_q_o(vq10), .range_err_q_o(errq10)
  );

  typedef struct {
    logic        en;
    logic [3:0]  val;
    logic [15:0] code;
    logic        err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_code(input int ow, input logic en, input logic [3:0] v);
    if (en && int'(v) < ow) return 16'(1) << v;
    return 16'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t t16[19];
  vec_t t10[5];

  logic [15:0] m_c16, m_c10;
  logic        m_v16, m_e16, m_v10, m_e10;

  initial begin
    t16[0]  = '{1'b1, 4'd0,  16'h0001, 1'b0};
    t16[1]  = '{1'b1, 4'd1,  16'h0002, 1'b0};
    t16[2]  = '{1'b1, 4'd2,  16'h0004, 1'b0};
    t16[3]  = '{1'b1, 4'd3,  16'h0008, 1'b0};
    t16[4]  = '{1'b1, 4'd4,  16'h0010, 1'b0};
    t16[5]  = '{1'b1, 4'd5,  16'h0020, 1'b0};
    t16[6]  = '{1'b1, 4'd6,  16'h0040, 1'b0};
    t16[7]  = '{1'b1, 4'd7,  16'h0080, 1'b0};
    t16[8]  = '{1'b1, 4'd8,  16'h0100, 1'b0};
    t16[9]  = '{1'b1, 4'd9,  16'h0200, 1'b0};
    t16[10] = '{1'b1, 4'd10, 16'h0400, 1'b0};
    t16[11] = '{1'b1, 4'd11, 16'h0800, 1'b0};
    t16[12] = '{1'b1, 4'd12, 16'h1000, 1'b0};
    t16[13] = '{1'b1, 4'd13, 16'h2000, 1'b0};
    t16[14] = '{1'b1, 4'd14, 16'h4000, 1'b0};
    t16[15] = '{1'b1, 4'd15, 16'h8000, 1'b0};
    t16[16] = '{1'b0, 4'd0,  16'h0000, 1'b0};
    t16[17] = '{1'b0, 4'd7,  16'h0000, 1'b0};
    t16[18] = '{1'b0, 4'd15, 16'h0000, 1'b0};
    t10[0]  = '{1'b1, 4'd9,  16'h0200, 1'b0};
    t10[1]  = '{1'b1, 4'd10, 16'h0000, 1'b1};
    t10[2]  = '{1'b1, 4'd15, 16'h0000, 1'b1};
    t10[3]  = '{1'b1, 4'd0,  16'h0001, 1'b0};
    t10[4]  = '{1'b0, 4'd12, 16'h0000, 1'b0};

    rst = 1'b1; v16 = 4'd5; en16 = 1'b1; v10 = 4'd0; en10 = 1'b0;
    tick(); tick();
    check("rst code_q16", 32'(codeq16), 32'h0);
    check("rst valid16",  32'(vq16),    32'h0);
    check("rst err_q16",  32'(errq16),  32'h0);
    check("rst comb16",   32'(code16),  32'h0020);

    // Combinational table scans; no edge is needed for these.
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      v16 = t16[i].val; en16 = t16[i].en;
      #1;
      check($sformatf("w16 code[%0d]", i), 32'(code16), 32'(t16[i].code));
      check($sformatf("w16 err[%0d]", i),  32'(err16),  32'(t16[i].err));
    end
    for (int i = 0; i < 5; i++) begin
      v10 = t10[i].val; en10 = t10[i].en;
      #1;
      check($sformatf("w10 code[%0d]", i), 32'(code10), 32'(t10[i].code));
      check($sformatf("w10 err[%0d]", i),  32'(err10),  32'(t10[i].err));
    end

    // Enable low, then registered latency.
    @(negedge clk);
    rst = 1'b0; en16 = 1'b0; v16 = 4'd15; en10 = 1'b1; v10 = 4'd15;
    tick();
    check("enlow code_q16", 32'(codeq16), 32'h0);
    check("enlow valid16",  32'(vq16),    32'h0);
    check("oor err_q10",    32'(errq10),  32'h1);
    check("oor valid10",    32'(vq10),    32'h0);
    check("oor code_q10",   32'(codeq10), 32'h0);
    @(negedge clk);
    v16 = 4'd5; en16 = 1'b1; v10 = 4'd9;
    #1;
    check("pre-edge code_q16", 32'(codeq16), 32'h0);
    check("pre-edge valid16",  32'(vq16),    32'h0);
    tick();
    check("lat code_q16",  32'(codeq16), 32'h0020);
    check("lat valid16",   32'(vq16),    32'h1);
    check("lat code_q10",  32'(codeq10), 32'h200);
    check("lat valid10",   32'(vq10),    32'h1);
    check("lat err_q10",   32'(errq10),  32'h0);
    @(negedge clk);
    v16 = 4'd2;
    #1;
    check("hold code_q16", 32'(codeq16), 32'h0020);
    tick();
    check("chg code_q16",  32'(codeq16), 32'h0004);

    // Reset mid-stream.
    @(negedge clk);
    v16 = 4'd5;
    tick();
    check("pre-rst code_q16", 32'(codeq16), 32'h0020);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid-rst code_q16", 32'(codeq16), 32'h0);
    check("mid-rst valid16",  32'(vq16),    32'h0);
    check("mid-rst comb16",   32'(code16),  32'h0020);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post-rst code_q16", 32'(codeq16), 32'h0020);
    check("post-rst valid16",  32'(vq16),    32'h1);

    // Random against a reference model.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 9) == 0);
      v16  = 4'($urandom_range(0, 15));
      en16 = 1'($urandom_range(0, 1));
      v10  = 4'($urandom_range(0, 15));
      en10 = 1'($urandom_range(0, 1));
      #1;
      check("rnd code16", 32'(code16), 32'(ref_code(16, en16, v16)));
      check("rnd err16",  32'(err16),  32'h0);
      check("rnd code10", 32'(code10), 32'(ref_code(10, en10, v10)));
      check("rnd err10",  32'(err10),  32'(en10 && v10 >= 4'd10));
      m_c16 = rst ? 16'h0 : ref_code(16, en16, v16);
      m_v16 = !rst && en16;
      m_e16 = 1'b0;
      m_c10 = rst ? 16'h0 : ref_code(10, en10, v10);
      m_v10 = !rst && en10 && v10 < 4'd10;
      m_e10 = !rst && en10 && v10 >= 4'd10;
      tick();
      check("rnd code_q16", 32'(codeq16), 32'(m_c16));
      check("rnd valid16",  32'(vq16),    32'(m_v16));
      check("rnd err_q16",  32'(errq16),  32'(m_e16));
      check("rnd code_q10", 32'(codeq10), 32'(m_c10));
      check("rnd valid10",  32'(vq10),    32'(m_v10));
      check("rnd err_q10",  32'(errq10),  32'(m_e10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
